execute_stage: RTL

- Execute (EX) stage. Sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Computes the ALU result for R/I-type instructions and owns the HI/LO registers.
- Runs MULT/MULTU/DIV/DIVU on an iterative 32-step multi-cycle unit. While that unit is busy, the block stalls the front of the pipeline.
- Outputs feed the EX/MEM register.

---
 rtl/execute_stage.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// EX stage: ALU, HI/LO registers and an iterative 32-step mul/div unit.
// Define MULDIV_EN to build the mul/div unit; otherwise its functs are NOPs.
module execute_stage #(
    parameter int NB_DATA     = 32,
    parameter int NB_REG      = 5,
    parameter int NB_FUNCTION = 6,
    parameter int NB_OP       = 6
) (
    input  logic                   clock,
    input  logic                   reset_i,
    input  logic [NB_OP-1:0]       opcode_i,
    input  logic [NB_FUNCTION-1:0] function_i,
    input  logic                   tipeI_i,
    input  logic [NB_DATA-1:0]     data_ra_i,
    input  logic [NB_DATA-1:0]     data_rb_i,
    input  logic [NB_DATA-1:0]     inm_ext_i,
    input  logic                   halt_i,
    output logic [NB_DATA-1:0]     alu_result_o,
    output logic [NB_DATA-1:0]     store_data_o,
    output logic [NB_DATA-1:0]     hi_o,
    output logic [NB_DATA-1:0]     lo_o,
    output logic                   busy_o,
    output logic                   md_done_o
);

    logic [NB_DATA-1:0] op_b;
    logic [NB_DATA-1:0] imm_zext;
    logic [NB_DATA-1:0] alu_res;
    logic [NB_REG-1:0]  shamt;
    logic [NB_REG-1:0]  shvar;
    logic               r_type;
    logic               mt_hi;
    logic               mt_lo;
    logic               md_write;
    logic [NB_DATA-1:0] md_hi;
    logic [NB_DATA-1:0] md_lo;
    logic [NB_DATA-1:0] hi_q;
    logic [NB_DATA-1:0] lo_q;

    assign op_b     = tipeI_i ? inm_ext_i : data_rb_i;
    assign imm_zext = {{(NB_DATA-16){1'b0}}, inm_ext_i[15:0]};
    assign shamt    = inm_ext_i[10:6];
    assign shvar    = data_ra_i[NB_REG-1:0];
    assign r_type   = (opcode_i == '0);
    assign mt_hi    = r_type && !halt_i && (function_i == 6'h11);
    assign mt_lo    = r_type && !halt_i && (function_i == 6'h13);

    always_comb begin
        alu_res = '0;
        if (!halt_i) begin
            if (r_type) begin
                unique case (function_i)
                    6'h20, 6'h21: alu_res = data_ra_i + op_b;
                    6'h22, 6'h23: alu_res = data_ra_i - op_b;
                    6'h24: alu_res = data_ra_i & op_b;
                    6'h25: alu_res = data_ra_i | op_b;
                    6'h26: alu_res = data_ra_i ^ op_b;
                    6'h27: alu_res = ~(data_ra_i | op_b);
                    6'h2A: alu_res = {{(NB_DATA-1){1'b0}},
                                      $signed(data_ra_i) < $signed(op_b)};
                    6'h2B: alu_res = {{(NB_DATA-1){1'b0}}, data_ra_i < op_b};
                    6'h00: alu_res = data_rb_i << shamt;
                    6'h02: alu_res = data_rb_i >> shamt;
                    6'h03: alu_res = $unsigned($signed(data_rb_i) >>> shamt);
                    6'h04: alu_res = data_rb_i << shvar;
                    6'h06: alu_res = data_rb_i >> shvar;
                    6'h07: alu_res = $unsigned($signed(data_rb_i) >>> shvar);
                    6'h10: alu_res = hi_q;
                    6'h12: alu_res = lo_q;
                    default: alu_res = '0;
                endcase
            end else begin
                unique case (opcode_i)
                    6'h08, 6'h09: alu_res = data_ra_i + op_b;
                    6'h0A: alu_res = {{(NB_DATA-1){1'b0}},
                                      $signed(data_ra_i) < $signed(op_b)};
                    6'h0B: alu_res = {{(NB_DATA-1){1'b0}}, data_ra_i < op_b};
                    6'h0C: alu_res = data_ra_i & imm_zext;
                    6'h0D: alu_res = data_ra_i | imm_zext;
                    6'h0E: alu_res = data_ra_i ^ imm_zext;
                    6'h0F: alu_res = imm_zext << 16;
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h28, 6'h29, 6'h2A, 6'h2B:
                        alu_res = data_ra_i + op_b;
                    default: alu_res = '0;
                endcase
            end
        end
    end

`ifdef MULDIV_EN
    localparam int NB_CNT = $clog2(NB_DATA);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state;
    state_t               state_nx;
    logic [NB_CNT-1:0]    cnt;
    logic [NB_DATA-1:0]   acc_hi;
    logic [NB_DATA-1:0]   acc_lo;
    logic [NB_DATA-1:0]   opnd;
    logic                 neg_q;
    logic                 neg_r;
    logic                 is_mul;
    logic                 is_div;
    logic                 div_zero;
    logic                 a_neg;
    logic                 b_neg;
    logic [NB_DATA-1:0]   a_mag;
    logic [NB_DATA-1:0]   b_mag;
    logic [NB_DATA:0]     mul_sum;
    logic [NB_DATA:0]     div_sh;
    logic                 div_ge;
    logic [NB_DATA-1:0]   step_hi;
    logic [NB_DATA-1:0]   step_lo;
    logic [2*NB_DATA-1:0] prod;
    logic                 busy;

    assign is_mul = r_type && !halt_i &&
                    (function_i == 6'h18 || function_i == 6'h19);
    assign is_div = r_type && !halt_i &&
                    (function_i == 6'h1A || function_i == 6'h1B);
    assign div_zero = is_div && (data_rb_i == '0);
    // Even functs (MULT/DIV) are the signed variants.
    assign a_neg = !function_i[0] && data_ra_i[NB_DATA-1];
    assign b_neg = !function_i[0] && data_rb_i[NB_DATA-1];
    assign a_mag = a_neg ? -data_ra_i : data_ra_i;
    assign b_mag = b_neg ? -data_rb_i : data_rb_i;

    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_sh  = {acc_hi, acc_lo[NB_DATA-1]};
    assign div_ge  = (div_sh >= {1'b0, opnd});

    always_comb begin
        if (state == MUL) begin
            {step_hi, step_lo} = {mul_sum, acc_lo[NB_DATA-1:1]};
        end else begin
            step_hi = div_ge ? (div_sh[NB_DATA-1:0] - opnd)
                             : div_sh[NB_DATA-1:0];
            step_lo = {acc_lo[NB_DATA-2:0], div_ge};
        end
    end

    assign prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        md_done_o = 1'b0;
        md_write  = 1'b0;
        md_hi     = '0;
        md_lo     = '0;
        unique case (state)
            IDLE: begin
                if (is_mul || is_div) begin
                    busy = 1'b1;
                    if (div_zero) begin
                        state_nx = DONE;
                        md_write = 1'b1;
                        md_hi    = data_ra_i;
                        md_lo    = '1;
                    end else begin
                        state_nx = is_mul ? MUL : DIV;
                    end
                end
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (cnt == NB_CNT'(NB_DATA-1)) begin
                    state_nx = DONE;
                    md_write = 1'b1;
                    if (state == MUL) begin
                        {md_hi, md_lo} = prod;
                    end else begin
                        md_hi = neg_r ? -step_hi : step_hi;
                        md_lo = neg_q ? -step_lo : step_lo;
                    end
                end
            end
            DONE: begin
                md_done_o = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A held mul/div must not request a stall while reset is asserted.
    assign busy_o = busy & reset_i;

    always_ff @(posedge clock or negedge reset_i) begin
        if (!reset_i) begin
            state  <= IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if ((is_mul || is_div) && !div_zero) begin
                    cnt    <= '0;
                    acc_hi <= '0;
                    acc_lo <= is_mul ? b_mag : a_mag;
                    opnd   <= is_mul ? a_mag : b_mag;
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                end
            end else if (state == MUL || state == DIV) begin
                cnt    <= cnt + 1'b1;
                acc_hi <= step_hi;
                acc_lo <= step_lo;
            end
        end
    end

    a_no_hilo_clash: assert property (@(posedge clock) disable iff (!reset_i)
        !(md_write && (mt_hi || mt_lo)));
`else
    assign busy_o    = 1'b0;
    assign md_done_o = 1'b0;
    assign md_write  = 1'b0;
    assign md_hi     = '0;
    assign md_lo     = '0;
`endif

    always_ff @(posedge clock or negedge reset_i) begin
        if (!reset_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_write) begin
            hi_q <= md_hi;
            lo_q <= md_lo;
        end else begin
            if (mt_hi) hi_q <= data_ra_i;
            if (mt_lo) lo_q <= data_ra_i;
        end
    end

    assign alu_result_o = alu_res;
    assign store_data_o = data_rb_i;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

endmodule
